// File: rtl/button_command_arbiter_if.sv
// Command handshake between the button arbiter and the game FSM.
interface button_command_arbiter_if #(
  parameter int N_BTN = 4
);
  logic             cmd_valid;
  logic [N_BTN-1:0] cmd_onehot;
  logic             cmd_ready;

  modport master (output cmd_valid, output cmd_onehot, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_onehot, output cmd_ready);
endinterface

// File: rtl/button_command_arbiter.sv
// Synchronises, debounces and edge-detects front-panel buttons, then offers
// pending presses one at a time, lowest index first, over a valid/ready handshake.
module button_command_arbiter #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [N_BTN-1:0]            i_btn,
  button_command_arbiter_if.master    cmd_if,
  output logic [N_BTN-1:0]            o_pending,
  output logic                        o_dropped
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_t;

  logic [N_BTN-1:0] r_sync1;
  logic [N_BTN-1:0] r_sync2;
  logic [N_BTN-1:0] r_db;
  logic [N_BTN-1:0] r_db_dly;
  logic [CNT_W-1:0] r_cnt [N_BTN];
  logic [N_BTN-1:0] r_pending;
  logic             r_dropped;
  state_t           r_state;
  logic             r_cmd_valid;
  logic [N_BTN-1:0] r_cmd_onehot;

  logic [N_BTN-1:0] w_press;
  logic [N_BTN-1:0] w_grant;
  logic [N_BTN-1:0] w_clear;
  state_t           w_state_nxt;
  logic             w_valid_nxt;
  logic [N_BTN-1:0] w_onehot_nxt;

  // Two-flop synchroniser, per-button debounce counter and edge-detect delay.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1  <= {N_BTN{1'b0}};
      r_sync2  <= {N_BTN{1'b0}};
      r_db     <= {N_BTN{1'b0}};
      r_db_dly <= {N_BTN{1'b0}};
      for (int i = 0; i < N_BTN; i++) begin
        r_cnt[i] <= {CNT_W{1'b0}};
      end
    end else begin
      r_sync1  <= i_btn;
      r_sync2  <= r_sync1;
      r_db_dly <= r_db;
      for (int i = 0; i < N_BTN; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_cnt[i] <= {CNT_W{1'b0}};
        end else if (r_cnt[i] == CNT_MAX) begin
          r_db[i]  <= r_sync2[i];
          r_cnt[i] <= {CNT_W{1'b0}};
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign w_press = r_db & ~r_db_dly;
  // Isolate the lowest set pending bit: that is the highest-priority button.
  assign w_grant = r_pending & (~r_pending + N_BTN'(1));

  // Offer FSM next-state and registered-output values.
  always_comb begin
    w_state_nxt  = r_state;
    w_valid_nxt  = r_cmd_valid;
    w_onehot_nxt = r_cmd_onehot;
    w_clear      = {N_BTN{1'b0}};
    case (r_state)
      ST_IDLE: begin
        if (|r_pending) begin
          w_state_nxt  = ST_OFFER;
          w_valid_nxt  = 1'b1;
          w_onehot_nxt = w_grant;
          w_clear      = w_grant;
        end else begin
          w_valid_nxt  = 1'b0;
          w_onehot_nxt = {N_BTN{1'b0}};
        end
      end
      ST_OFFER: begin
        if (cmd_if.cmd_ready) begin
          w_state_nxt  = ST_IDLE;
          w_valid_nxt  = 1'b0;
          w_onehot_nxt = {N_BTN{1'b0}};
        end else begin
          w_state_nxt  = ST_OFFER;
          w_valid_nxt  = 1'b1;
          w_onehot_nxt = r_cmd_onehot;
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_valid_nxt  = 1'b0;
        w_onehot_nxt = {N_BTN{1'b0}};
      end
    endcase
  end

  // State and offer registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_cmd_valid  <= 1'b0;
      r_cmd_onehot <= {N_BTN{1'b0}};
    end else begin
      r_state      <= w_state_nxt;
      r_cmd_valid  <= w_valid_nxt;
      r_cmd_onehot <= w_onehot_nxt;
    end
  end

  // Pending presses; a press landing on the bit being granted re-arms it instead of dropping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pending <= {N_BTN{1'b0}};
      r_dropped <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~w_clear) | w_press;
      r_dropped <= |(w_press & r_pending & ~w_clear);
    end
  end

  assign cmd_if.cmd_valid  = r_cmd_valid;
  assign cmd_if.cmd_onehot = r_cmd_onehot;
  assign o_pending         = r_pending;
  assign o_dropped         = r_dropped;
endmodule

// File: tb/tb_button_command_arbiter.sv
// Scoreboard bench for button_command_arbiter with DEBOUNCE_CYCLES=4.
module tb_button_command_arbiter;
  localparam int N_BTN = 4;
  localparam int DC    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_BTN-1:0] btn;
  logic [N_BTN-1:0] pending;
  logic             dropped;

  button_command_arbiter_if #(.N_BTN(N_BTN)) bus ();

  button_command_arbiter #(.N_BTN(N_BTN), .DEBOUNCE_CYCLES(DC)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_btn     (btn),
    .cmd_if    (bus),
    .o_pending (pending),
    .o_dropped (dropped)
  );

  always #5 clk = ~clk;

  int               n_checks = 0;
  int               n_pass   = 0;
  int               cyc      = 0;
  int               valid_cycles = 0;
  int               drop_cnt = 0;
  logic [N_BTN-1:0] exp_q [$];
  int               xfer_cyc [$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max_cyc);
    for (int i = 0; i < max_cyc && !bus.cmd_valid; i++) tick(1);
    check_eq("wait_valid", {31'd0, bus.cmd_valid}, 32'd1);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every handshake is checked against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.cmd_valid) valid_cycles++;
      if (dropped) drop_cnt++;
      if (bus.cmd_valid && bus.cmd_ready) begin
        xfer_cyc.push_back(cyc);
        if (exp_q.size() > 0) check_eq("cmd_order", {28'd0, bus.cmd_onehot}, {28'd0, exp_q.pop_front()});
        else check_eq("cmd_unexpected", {28'd0, bus.cmd_onehot}, 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int pat [8];
    int vc;
    int d0;
    pat = '{1, 1, 1, 0, 1, 1, 1, 0};
    rst = 1'b1;
    btn = 4'b0000;
    bus.cmd_ready = 1'b1;
    tick(3);
    check_eq("rst_valid",   {31'd0, bus.cmd_valid}, 32'd0);
    check_eq("rst_onehot",  {28'd0, bus.cmd_onehot}, 32'd0);
    check_eq("rst_pending", {28'd0, pending}, 32'd0);
    check_eq("rst_dropped", {31'd0, dropped}, 32'd0);
    rst = 1'b0;
    tick(2);

    // Single press: offer appears after edge k+7 and lasts one cycle.
    btn = 4'b0001;
    exp_q.push_back(4'b0001);
    tick(6);
    check_eq("t1_early_valid", {31'd0, bus.cmd_valid}, 32'd0);
    tick(1);
    check_eq("t1_pending", {28'd0, pending}, 32'h1);
    check_eq("t1_valid_k6", {31'd0, bus.cmd_valid}, 32'd0);
    tick(1);
    check_eq("t1_valid_k7", {31'd0, bus.cmd_valid}, 32'd1);
    check_eq("t1_onehot",   {28'd0, bus.cmd_onehot}, 32'h1);
    tick(1);
    check_eq("t1_one_cycle", {31'd0, bus.cmd_valid}, 32'd0);
    check_eq("t1_pend_clr",  {28'd0, pending}, 32'h0);
    tick(1);
    btn = 4'b0000;
    tick(12);
    check_eq("t1_sb_empty", exp_q.size(), 32'd0);

    // Bounce shorter than the debounce window, then a clean hold.
    vc = valid_cycles;
    for (int i = 0; i < 8; i++) begin
      btn[1] = pat[i][0];
      tick(1);
    end
    btn = 4'b0000;
    tick(8);
    check_eq("t2_bounce_pend",  {28'd0, pending}, 32'h0);
    check_eq("t2_bounce_valid", valid_cycles, vc);
    btn[1] = 1'b1;
    exp_q.push_back(4'b0010);
    tick(6);
    btn = 4'b0000;
    tick(14);
    check_eq("t2_one_cmd",   valid_cycles, vc + 1);
    check_eq("t2_sb_empty",  exp_q.size(), 32'd0);

    // Simultaneous presses, stalled consumer, then drained in priority order.
    bus.cmd_ready = 1'b0;
    btn = 4'b1011;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b1000);
    wait_valid(20);
    check_eq("t3_first_offer", {28'd0, bus.cmd_onehot}, 32'h1);
    check_eq("t3_pending",     {28'd0, pending}, 32'hA);
    tick(5);
    check_eq("t3_held_valid",  {31'd0, bus.cmd_valid}, 32'd1);
    check_eq("t3_held_onehot", {28'd0, bus.cmd_onehot}, 32'h1);
    btn = 4'b0000;
    tick(10);
    xfer_cyc.delete();
    bus.cmd_ready = 1'b1;
    tick(8);
    check_eq("t3_xfer_count", xfer_cyc.size(), 32'd3);
    if (xfer_cyc.size() >= 3) begin
      check_eq("t3_gap01", xfer_cyc[1] - xfer_cyc[0], 32'd2);
      check_eq("t3_gap12", xfer_cyc[2] - xfer_cyc[1], 32'd2);
    end
    check_eq("t3_sb_empty", exp_q.size(), 32'd0);

    // Coalesce: btn[2] pressed twice while an offer is stalled.
    bus.cmd_ready = 1'b0;
    btn = 4'b0001;
    exp_q.push_back(4'b0001);
    tick(6);
    btn = 4'b0000;
    tick(8);
    wait_valid(10);
    d0 = drop_cnt;
    btn = 4'b0100;
    exp_q.push_back(4'b0100);
    tick(6);
    btn = 4'b0000;
    tick(8);
    btn = 4'b0100;
    tick(6);
    btn = 4'b0000;
    tick(10);
    check_eq("t4_pending", {28'd0, pending}, 32'h4);
    check_eq("t4_dropped", drop_cnt - d0, 32'd1);
    check_eq("t4_offer",   {28'd0, bus.cmd_onehot}, 32'h1);
    bus.cmd_ready = 1'b1;
    tick(6);
    check_eq("t4_sb_empty", exp_q.size(), 32'd0);
    check_eq("t4_pend_clr", {28'd0, pending}, 32'h0);

    // Reset mid-offer discards the offer and all pending presses.
    bus.cmd_ready = 1'b0;
    btn = 4'b0001;
    tick(6);
    btn = 4'b0110;
    for (int i = 0; i < 20 && pending != 4'b0110; i++) tick(1);
    check_eq("t5_pending", {28'd0, pending}, 32'h6);
    check_eq("t5_valid",   {31'd0, bus.cmd_valid}, 32'd1);
    check_eq("t5_onehot",  {28'd0, bus.cmd_onehot}, 32'h1);
    btn = 4'b0000;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_eq("t5_rst_valid",   {31'd0, bus.cmd_valid}, 32'd0);
    check_eq("t5_rst_onehot",  {28'd0, bus.cmd_onehot}, 32'd0);
    check_eq("t5_rst_pending", {28'd0, pending}, 32'd0);
    vc = valid_cycles;
    bus.cmd_ready = 1'b1;
    tick(20);
    check_eq("t5_no_cmd",   valid_cycles, vc);
    check_eq("t5_sb_empty", exp_q.size(), 32'd0);

    // Button held through reset is a fresh press once reset releases.
    btn = 4'b1000;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    exp_q.push_back(4'b1000);
    tick(7);
    check_eq("t6_valid_k6", {31'd0, bus.cmd_valid}, 32'd0);
    tick(1);
    check_eq("t6_valid_k7", {31'd0, bus.cmd_valid}, 32'd1);
    check_eq("t6_onehot",   {28'd0, bus.cmd_onehot}, 32'h8);
    tick(1);
    btn = 4'b0000;
    tick(12);
    check_eq("t6_sb_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
